// File: rtl/frame_monitor_pkg.sv
// Shared types and register map for the frame monitor sink.
// Header beat count, monitor FSM states and Avalon byte addresses live here.
package frame_monitor_pkg;

  localparam int DATA_W        = 16;
  localparam int MIN_HDR_BEATS = 8;
  localparam int HDR_BYTES     = 16;

  localparam logic [7:0] ADDR_LEN_LO  = 8'd12;
  localparam logic [7:0] ADDR_CHK0    = 8'd16;
  localparam logic [7:0] ADDR_FCNT0   = 8'd20;
  localparam logic [7:0] ADDR_RUNT    = 8'd24;
  localparam logic [7:0] ADDR_LENERR  = 8'd25;
  localparam logic [7:0] ADDR_STATUS  = 8'd26;
  localparam logic [7:0] ADDR_STALL   = 8'd32;
  localparam logic [7:0] ADDR_CTRL    = 8'd33;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_HDR,
    MON_PAYLOAD
  } mon_state_t;

endpackage

// File: rtl/frame_monitor_parser.sv
// Frame header parser: tracks beat position, captures the 16-byte header and
// classifies each accepted tlast as good, runt or length error.
import frame_monitor_pkg::*;

module frame_header_parser (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   beat_acc,
  input  logic [DATA_W-1:0]      tdata,
  input  logic                   tlast,
  output mon_state_t             state,
  output logic [HDR_BYTES*8-1:0] hdr_next,
  output logic                   frame_start,
  output logic                   payload_beat,
  output logic                   good,
  output logic                   runt,
  output logic                   len_err
);

  logic [15:0]            beat_idx;
  logic [HDR_BYTES*8-1:0] shadow_q;
  logic [15:0]            hdr_len;
  logic [16:0]            exp_last;
  logic                   last_acc;
  logic                   len_match;

  // Header image including the beat being accepted this cycle, so a frame
  // that ends on its type beat still commits a complete header.
  always_comb begin
    hdr_next = shadow_q;
    if (beat_acc && (beat_idx < 16'(MIN_HDR_BEATS)))
      hdr_next[{beat_idx[2:0], 4'b0000} +: 16] = {tdata[7:0], tdata[15:8]};
  end

  assign hdr_len      = shadow_q[ADDR_LEN_LO*8 +: 16];
  assign exp_last     = ((({1'b0, hdr_len}) + 17'd1) >> 1) + 17'(MIN_HDR_BEATS - 1);
  assign last_acc     = beat_acc && tlast;
  assign len_match    = ({1'b0, beat_idx} == exp_last);
  assign frame_start  = beat_acc && (state == MON_IDLE);
  assign payload_beat = beat_acc && (state == MON_PAYLOAD);
  assign runt         = last_acc && (beat_idx < 16'(MIN_HDR_BEATS - 1));
  assign good         = last_acc && !runt && len_match;
  assign len_err      = last_acc && !runt && !len_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MON_IDLE;
      beat_idx <= '0;
    end else if (beat_acc) begin
      if (tlast) begin
        state    <= MON_IDLE;
        beat_idx <= '0;
      end else begin
        beat_idx <= beat_idx + 16'd1;
        case (state)
          MON_IDLE:    state <= MON_HDR;
          MON_HDR:     if (beat_idx == 16'(MIN_HDR_BEATS - 1)) state <= MON_PAYLOAD;
          default:     state <= MON_PAYLOAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc)
      shadow_q <= hdr_next;
  end

endmodule

// File: rtl/frame_monitor.sv
// Sink-side frame monitor: checksum, frame/error counters, committed header
// snapshot, 8-bit Avalon-MM register access and programmable tready stalls.
import frame_monitor_pkg::*;

module frame_monitor (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ingress_port_tdata,
  input  logic              ingress_port_tvalid,
  input  logic              ingress_port_tlast,
  output logic              ingress_port_tready,
  input  logic [7:0]        writedata,
  input  logic              write,
  input  logic              chipselect,
  input  logic [7:0]        address,
  input  logic              read,
  output logic [7:0]        readdata
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  mon_state_t             state;
  logic [HDR_BYTES*8-1:0] hdr_next;
  logic                   frame_start, payload_beat, good, runt, len_err;
  logic                   beat_acc;
  logic [2:0]             phase;
  logic [7:0]             stall_mask;
  logic [31:0]            checksum_work, chk_next, pay_sum;
  logic [HDR_BYTES*8-1:0] snap_hdr;
  logic [31:0]            snap_chk;
  logic [31:0]            frame_count;
  logic [7:0]             runt_count, len_err_count;
  logic                   sticky_err;
  logic                   clr;
  logic [7:0]             rd_mux;

  assign ingress_port_tready = !reset && !stall_mask[phase];
  assign beat_acc            = ingress_port_tvalid && ingress_port_tready;

  frame_header_parser u_parser (
    .clk          (clk),
    .reset        (reset),
    .beat_acc     (beat_acc),
    .tdata        (ingress_port_tdata),
    .tlast        (ingress_port_tlast),
    .state        (state),
    .hdr_next     (hdr_next),
    .frame_start  (frame_start),
    .payload_beat (payload_beat),
    .good         (good),
    .runt         (runt),
    .len_err      (len_err)
  );

  assign pay_sum  = {24'd0, ingress_port_tdata[15:8]} + {24'd0, ingress_port_tdata[7:0]};
  assign chk_next = checksum_work + (payload_beat ? pay_sum : 32'd0);
  assign clr      = chipselect && write && (address == ADDR_CTRL) && writedata[0];

  always_ff @(posedge clk) begin
    if (frame_start)
      checksum_work <= '0;
    else if (payload_beat)
      checksum_work <= chk_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= '0;
      stall_mask <= '0;
      snap_hdr   <= '0;
      snap_chk   <= '0;
    end else begin
      phase <= phase + 3'd1;
      if (chipselect && write && (address == ADDR_STALL))
        stall_mask <= writedata;
      // Snapshot commit is independent of the counter clear.
      if (good) begin
        snap_hdr <= hdr_next;
        snap_chk <= chk_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      frame_count   <= '0;
      runt_count    <= '0;
      len_err_count <= '0;
      sticky_err    <= 1'b0;
    end else begin
      if (good)    frame_count   <= frame_count + 32'd1;
      if (runt)    runt_count    <= sat_inc8(runt_count);
      if (len_err) begin
        len_err_count <= sat_inc8(len_err_count);
        sticky_err    <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = 8'd0;
    if (address < ADDR_CHK0)
      rd_mux = snap_hdr[{address[3:0], 3'b000} +: 8];
    else if (address < ADDR_FCNT0)
      rd_mux = snap_chk[{address[1:0], 3'b000} +: 8];
    else if (address < ADDR_RUNT)
      rd_mux = frame_count[{address[1:0], 3'b000} +: 8];
    else if (address == ADDR_RUNT)
      rd_mux = runt_count;
    else if (address == ADDR_LENERR)
      rd_mux = len_err_count;
    else if (address == ADDR_STATUS)
      rd_mux = {6'd0, sticky_err, state != MON_IDLE};
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= (chipselect && read) ? rd_mux : 8'd0;
  end

endmodule

// File: tb/tb_frame_monitor.sv
// Directed bench for frame_monitor: good, runt and length-error frames,
// stall pattern, clear/commit collision and reset mid-frame.
module tb_frame_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tdata;
  logic        tvalid, tlast, tready;
  logic [7:0]  writedata, address, readdata;
  logic        write, chipselect, read;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] beats[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  frame_monitor dut (
    .clk                 (clk),
    .reset               (reset),
    .ingress_port_tdata  (tdata),
    .ingress_port_tvalid (tvalid),
    .ingress_port_tlast  (tlast),
    .ingress_port_tready (tready),
    .writedata           (writedata),
    .write               (write),
    .chipselect          (chipselect),
    .address             (address),
    .read                (read),
    .readdata            (readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    tdata = d; tlast = l; tvalid = 1'b1;
    while (!tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!tready) check("tready_wait", 32'(tready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic stream_idle();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic build_hdr(input logic [7:0] seed, input logic [15:0] len);
    beats.delete();
    for (int k = 0; k < 6; k++)
      beats.push_back({seed + 8'(2*k), seed + 8'(2*k+1)});
    beats.push_back({len[7:0], len[15:8]});
    beats.push_back(16'h0800);
  endtask

  task automatic send_frame();
    for (int i = 0; i < beats.size(); i++)
      send_beat(beats[i], i == beats.size() - 1);
    stream_idle();
  endtask

  task automatic rd8(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd32(input logic [7:0] a, output logic [31:0] d);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      rd8(a + 8'(i), b);
      d[i*8 +: 8] = b;
    end
  endtask

  task automatic wr8(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    #1 check("tready_in_reset", 32'(tready), 32'd0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    reset = 1'b1; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    writedata = '0; address = '0; write = 1'b0; chipselect = 1'b0; read = 1'b0;

    do_reset(4);
    #1 check("tready_after_reset", 32'(tready), 32'd1);
    check("readdata_reset", 32'(readdata), 32'd0);
    rd32(8'd20, w); check("fcnt_reset", w, 32'd0);
    rd8(8'd26, b);  check("status_reset", 32'(b), 32'd0);

    // Good frame, len 4, payload 01 02 03 04
    build_hdr(8'h11, 16'd4);
    beats.push_back(16'h0102); beats.push_back(16'h0304);
    send_frame();
    rd32(8'd20, w); check("fcnt_good", w, 32'd1);
    rd32(8'd16, w); check("chk_good", w, 32'h0000_000A);
    rd8(8'd16, b);  check("chk_byte0", 32'(b), 32'h0A);
    rd8(8'd12, b);  check("len_lo", 32'(b), 32'h04);
    rd8(8'd13, b);  check("len_hi", 32'(b), 32'h00);
    rd8(8'd0, b);   check("mac0", 32'(b), 32'h11);
    rd8(8'd11, b);  check("mac11", 32'(b), 32'h1C);
    rd8(8'd14, b);  check("type_hi", 32'(b), 32'h08);

    wr8(8'd33, 8'h01);
    rd32(8'd20, w); check("fcnt_cleared", w, 32'd0);

    // Runt: tlast on beat 3
    build_hdr(8'h50, 16'd4);
    for (int i = 0; i < 4; i++) send_beat(beats[i], i == 3);
    stream_idle();
    rd8(8'd24, b);  check("runt_cnt", 32'(b), 32'd1);
    rd32(8'd20, w); check("fcnt_after_runt", w, 32'd0);
    rd8(8'd0, b);   check("mac0_after_runt", 32'(b), 32'h11);
    rd32(8'd16, w); check("chk_after_runt", w, 32'h0A);

    // Length error: len 6 but only 2 payload beats
    build_hdr(8'h60, 16'd6);
    beats.push_back(16'h0101); beats.push_back(16'h0101);
    send_frame();
    rd8(8'd25, b);  check("lenerr_cnt", 32'(b), 32'd1);
    rd8(8'd26, b);  check("status_sticky", 32'(b), 32'h02);
    rd8(8'd0, b);   check("mac0_after_lenerr", 32'(b), 32'h11);

    // Stall pattern 0xAA: tready low on odd phases
    wr8(8'd32, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stall_pattern", 32'(tready), 32'(!(8'hAA >> (cyc % 8) & 8'h01)));
    end
    wr8(8'd33, 8'h01);
    for (int f = 0; f < 10; f++) begin
      build_hdr(8'h30, 16'd4);
      beats.push_back({8'(f), 8'(f+1)}); beats.push_back({8'(f+2), 8'(f+3)});
      send_frame();
    end
    rd32(8'd20, w); check("fcnt_stalled", w, 32'd10);
    rd32(8'd16, w); check("chk_stalled", w, 32'h2A);
    rd8(8'd25, b);  check("lenerr_stalled", 32'(b), 32'd0);
    rd8(8'd26, b);  check("status_stalled", 32'(b), 32'd0);
    wr8(8'd32, 8'h00);

    // Clear on the same edge as a good tlast
    build_hdr(8'h70, 16'd2);
    for (int i = 0; i < 8; i++) send_beat(beats[i], 1'b0);
    @(negedge clk);
    tdata = 16'h0506; tlast = 1'b1; tvalid = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'd33; writedata = 8'h01;
    #1 check("tready_collide", 32'(tready), 32'd1);
    @(posedge clk); #1;
    stream_idle(); chipselect = 1'b0; write = 1'b0;
    rd32(8'd20, w); check("fcnt_clear_wins", w, 32'd0);
    rd32(8'd16, w); check("chk_commit_on_clear", w, 32'h0B);
    rd8(8'd0, b);   check("mac0_commit_on_clear", 32'(b), 32'h70);

    // Reset during payload beat 3, then a len 2 frame AB CD
    build_hdr(8'h80, 16'd8);
    for (int i = 0; i < 11; i++) send_beat(i < 8 ? beats[i] : 16'h1111, 1'b0);
    stream_idle();
    do_reset(2);
    rd32(8'd16, w); check("chk_after_reset", w, 32'd0);
    build_hdr(8'h90, 16'd2);
    beats.push_back(16'hABCD);
    send_frame();
    rd32(8'd20, w); check("fcnt_after_reset", w, 32'd1);
    rd32(8'd16, w); check("chk_abcd", w, 32'h178);
    rd8(8'd25, b);  check("lenerr_after_reset", 32'(b), 32'd0);

    // Single-beat frame is a runt
    send_beat(16'h1234, 1'b1);
    stream_idle();
    rd8(8'd24, b);  check("runt_single", 32'(b), 32'd1);

    // Odd length sums both bytes of the last beat
    build_hdr(8'hA0, 16'd1);
    beats.push_back(16'h1020);
    send_frame();
    rd32(8'd20, w); check("fcnt_odd", w, 32'd2);
    rd32(8'd16, w); check("chk_odd", w, 32'h30);

    rd8(8'd40, b);  check("unmapped", 32'(b), 32'd0);
    @(posedge clk); #1;
    check("readdata_idle", 32'(readdata), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
